// File: rtl/loader_pkg.sv
// Shared types and constants for the byte-serial program loader.
package loader_pkg;

  typedef enum logic [2:0] {
    IDLE,
    HEADER,
    BYTE_HI,
    BYTE_LO,
    WRITE,
    CHECK,
    DONE,
    ERROR
  } loader_state_t;

  localparam int unsigned MAX_WORDS     = 32;
  localparam logic [7:0]  CHECKSUM_INIT = 8'h00;

endpackage

// File: rtl/program_loader.sv
// Assembles a byte-serial program image into 16-bit words, writes them to program
// memory and holds the core in reset until an image with a valid checksum is loaded.
module program_loader
  import loader_pkg::*;
#(
  parameter int unsigned INSTRUCTION_WIDTH = 16,
  parameter int unsigned PC_VALUE_WIDTH    = $clog2(MAX_WORDS),
  parameter int unsigned BYTE_WIDTH        = 8
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         load_start,
  input  logic                         byte_valid,
  input  logic [BYTE_WIDTH-1:0]        byte_data,
  output logic                         byte_ready,
  output logic                         pm_we,
  output logic [PC_VALUE_WIDTH-1:0]    pm_addr,
  output logic [INSTRUCTION_WIDTH-1:0] pm_wdata,
  output logic                         core_rst,
  output logic                         busy,
  output logic                         load_done,
  output logic                         load_error
);

  localparam int unsigned             CNT_W = PC_VALUE_WIDTH + 1;
  localparam logic [CNT_W-1:0]        MAX_N = CNT_W'(1) << PC_VALUE_WIDTH;
  localparam logic [BYTE_WIDTH-1:0]   MAX_N_B = BYTE_WIDTH'(MAX_N);

  loader_state_t           state, state_next;
  logic [BYTE_WIDTH-1:0]   checksum;
  logic [BYTE_WIDTH-1:0]   hi_byte;
  logic [CNT_W-1:0]        word_count;
  logic                    accept;
  logic                    hdr_bad;
  logic                    last_word;
  logic                    start_load;

  assign byte_ready = (state == HEADER) || (state == BYTE_HI) ||
                      (state == BYTE_LO) || (state == CHECK);
  assign accept     = byte_valid && byte_ready;
  assign hdr_bad    = (byte_data == '0) || (byte_data > MAX_N_B);
  // One extra bit so that N == 2**PC_VALUE_WIDTH still matches on the last address.
  assign last_word  = ({1'b0, pm_addr} == (word_count - CNT_W'(1)));
  assign start_load = (state_next == HEADER) && (state != HEADER);

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (load_start) state_next = HEADER;
      HEADER:  if (accept) state_next = hdr_bad ? ERROR : BYTE_HI;
      BYTE_HI: if (accept) state_next = BYTE_LO;
      BYTE_LO: if (accept) state_next = WRITE;
      WRITE:   state_next = last_word ? CHECK : BYTE_HI;
      CHECK:   if (accept) state_next = (byte_data == checksum) ? DONE : ERROR;
      DONE:    if (load_start) state_next = HEADER;
      ERROR:   if (load_start) state_next = HEADER;
      default: state_next = IDLE;
    endcase
  end

  // Status outputs are registered from state_next so they line up with the state flop.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      pm_we      <= 1'b0;
      pm_addr    <= '0;
      pm_wdata   <= '0;
      core_rst   <= 1'b1;
      busy       <= 1'b0;
      load_done  <= 1'b0;
      load_error <= 1'b0;
      checksum   <= BYTE_WIDTH'(CHECKSUM_INIT);
      word_count <= '0;
      hi_byte    <= '0;
    end else begin
      state      <= state_next;
      pm_we      <= (state == BYTE_LO) && accept;
      core_rst   <= (state_next != DONE);
      load_done  <= (state_next == DONE);
      load_error <= (state_next == ERROR);
      busy       <= (state_next == HEADER) || (state_next == BYTE_HI) ||
                    (state_next == BYTE_LO) || (state_next == WRITE) ||
                    (state_next == CHECK);

      if (start_load) begin
        checksum <= BYTE_WIDTH'(CHECKSUM_INIT);
        pm_addr  <= '0;
      end else if (accept && (state != CHECK)) begin
        checksum <= checksum ^ byte_data;
      end

      case (state)
        HEADER:  if (accept) word_count <= CNT_W'(byte_data);
        BYTE_HI: if (accept) hi_byte <= byte_data;
        BYTE_LO: if (accept) pm_wdata <= {hi_byte, byte_data};
        WRITE:   if (!last_word) pm_addr <= pm_addr + 1'b1;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_program_loader.sv
// Directed bench for program_loader: normal, bad-checksum, bad-header, full-size,
// mid-load reset and reload images with write logging on the falling edge.
module tb_program_loader;

  logic        clk = 1'b0;
  logic        rst;
  logic        load_start;
  logic        byte_valid;
  logic [7:0]  byte_data;
  logic        byte_ready;
  logic        pm_we;
  logic [4:0]  pm_addr;
  logic [15:0] pm_wdata;
  logic        core_rst;
  logic        busy;
  logic        load_done;
  logic        load_error;

  int vectors    = 0;
  int miscompares = 0;

  int          wr_count = 0;
  int          rdy_viol = 0;
  logic [4:0]  log_addr [0:255];
  logic [15:0] log_data [0:255];

  program_loader #(
    .INSTRUCTION_WIDTH(16),
    .PC_VALUE_WIDTH(5),
    .BYTE_WIDTH(8)
  ) dut (
    .clk(clk),
    .rst(rst),
    .load_start(load_start),
    .byte_valid(byte_valid),
    .byte_data(byte_data),
    .byte_ready(byte_ready),
    .pm_we(pm_we),
    .pm_addr(pm_addr),
    .pm_wdata(pm_wdata),
    .core_rst(core_rst),
    .busy(busy),
    .load_done(load_done),
    .load_error(load_error)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (pm_we) begin
      if (wr_count < 256) begin
        log_addr[wr_count] = pm_addr;
        log_data[wr_count] = pm_wdata;
      end
      if (byte_ready) rdy_viol = rdy_viol + 1;
      wr_count = wr_count + 1;
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic send_byte(input logic [7:0] b, input int gap);
    int t;
    repeat (gap) @(negedge clk);
    @(negedge clk);
    byte_valid = 1'b1;
    byte_data  = b;
    t = 0;
    while (!byte_ready && t < 50) begin
      @(negedge clk);
      t++;
    end
    if (t == 50) chk("byte_ready_timeout", 32'(t), 32'd0);
    @(posedge clk);
    #1;
    byte_valid = 1'b0;
  endtask

  task automatic pulse_start();
    @(negedge clk);
    load_start = 1'b1;
    @(negedge clk);
    load_start = 1'b0;
  endtask

  initial begin
    int base;
    int viol0;
    logic [7:0] cs;
    logic [7:0] hb, lb;

    rst = 1'b1; load_start = 1'b0; byte_valid = 1'b0; byte_data = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_core_rst", 32'(core_rst), 32'd1);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_pm_we", 32'(pm_we), 32'd0);
    chk("rst_pm_addr", 32'(pm_addr), 32'd0);
    chk("rst_done_err", {30'd0, load_done, load_error}, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("idle_ready", 32'(byte_ready), 32'd0);

    // Image 1: N=2, A1B2, 0304, checksum 02^A1^B2^03^04 = 16
    base = wr_count; viol0 = rdy_viol;
    pulse_start();
    chk("hdr_busy", 32'(busy), 32'd1);
    chk("hdr_core_rst", 32'(core_rst), 32'd1);
    send_byte(8'h02, 0);
    send_byte(8'hA1, 1);
    send_byte(8'hB2, 0);
    chk("lat_pm_we", 32'(pm_we), 32'd1);
    chk("lat_pm_wdata", 32'(pm_wdata), 32'hA1B2);
    chk("lat_pm_addr", 32'(pm_addr), 32'd0);
    send_byte(8'h03, 0);
    send_byte(8'h04, 2);
    send_byte(8'h16, 0);
    chk("img1_done", 32'(load_done), 32'd1);
    chk("img1_core_rst", 32'(core_rst), 32'd0);
    chk("img1_busy", 32'(busy), 32'd0);
    chk("img1_writes", 32'(wr_count - base), 32'd2);
    chk("img1_w0_addr", 32'(log_addr[base]), 32'd0);
    chk("img1_w0_data", 32'(log_data[base]), 32'hA1B2);
    chk("img1_w1_addr", 32'(log_addr[base+1]), 32'd1);
    chk("img1_w1_data", 32'(log_data[base+1]), 32'h0304);

    // Reload from DONE with a wrong checksum
    base = wr_count;
    @(negedge clk);
    load_start = 1'b1;
    @(posedge clk);
    #1;
    load_start = 1'b0;
    chk("reload_core_rst", 32'(core_rst), 32'd1);
    chk("reload_busy", 32'(busy), 32'd1);
    chk("reload_done_clr", 32'(load_done), 32'd0);
    send_byte(8'h02, 0);
    send_byte(8'hA1, 0);
    send_byte(8'hB2, 0);
    send_byte(8'h03, 0);
    send_byte(8'h04, 0);
    send_byte(8'h15, 0);
    chk("img2_error", 32'(load_error), 32'd1);
    chk("img2_done", 32'(load_done), 32'd0);
    chk("img2_core_rst", 32'(core_rst), 32'd1);
    chk("img2_writes", 32'(wr_count - base), 32'd2);
    @(negedge clk);
    chk("img2_error_sticky", 32'(load_error), 32'd1);

    // Illegal headers
    base = wr_count;
    pulse_start();
    chk("hdr0_err_clr", 32'(load_error), 32'd0);
    send_byte(8'h00, 0);
    chk("hdr0_error", 32'(load_error), 32'd1);
    chk("hdr0_busy", 32'(busy), 32'd0);
    pulse_start();
    send_byte(8'h21, 0);
    chk("hdr33_error", 32'(load_error), 32'd1);
    chk("hdr33_core_rst", 32'(core_rst), 32'd1);
    repeat (2) @(negedge clk);
    chk("hdr_bad_writes", 32'(wr_count - base), 32'd0);

    // Full image N=32 with random gaps and a stray load_start mid-load
    base = wr_count; viol0 = rdy_viol;
    pulse_start();
    cs = 8'h20;
    send_byte(8'h20, 0);
    for (int i = 0; i < 32; i++) begin
      hb = 8'(i) ^ 8'h5A;
      lb = 8'(i * 3);
      cs = cs ^ hb ^ lb;
      if (i == 10) pulse_start();
      send_byte(hb, $urandom_range(0, 3));
      send_byte(lb, $urandom_range(0, 3));
    end
    send_byte(cs, 1);
    chk("n32_done", 32'(load_done), 32'd1);
    chk("n32_writes", 32'(wr_count - base), 32'd32);
    chk("n32_ready_in_write", 32'(rdy_viol - viol0), 32'd0);
    chk("n32_addr_hold", 32'(pm_addr), 32'd31);
    for (int i = 0; i < 32; i++) begin
      chk("n32_addr", 32'(log_addr[base+i]), 32'(i));
      chk("n32_data", 32'(log_data[base+i]), {16'd0, 8'(i) ^ 8'h5A, 8'(i * 3)});
    end

    // Reset part-way through the payload, then a clean 1-word load
    pulse_start();
    send_byte(8'h03, 0);
    send_byte(8'h11, 0);
    send_byte(8'h22, 0);
    send_byte(8'h33, 0);
    #2;
    rst = 1'b1;
    #1;
    chk("arst_busy", 32'(busy), 32'd0);
    chk("arst_core_rst", 32'(core_rst), 32'd1);
    chk("arst_ready", 32'(byte_ready), 32'd0);
    chk("arst_pm_addr", 32'(pm_addr), 32'd0);
    chk("arst_pm_wdata", 32'(pm_wdata), 32'd0);
    chk("arst_flags", {30'd0, load_done, load_error}, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    base = wr_count;
    pulse_start();
    send_byte(8'h01, 0);
    send_byte(8'h12, 0);
    send_byte(8'h34, 0);
    send_byte(8'h27, 0);
    chk("post_rst_done", 32'(load_done), 32'd1);
    chk("post_rst_core_rst", 32'(core_rst), 32'd0);
    chk("post_rst_writes", 32'(wr_count - base), 32'd1);
    chk("post_rst_w0", {11'd0, log_addr[base], log_data[base]}, {11'd0, 5'd0, 16'h1234});

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

endmodule
